// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer
//   Read stage behind a single-clock FIFO. Pops words through the FIFO read port,
//   absorbs the FIFO's one-cycle registered read latency, and presents the words as
//   a valid/ready stream with a packet-boundary flag. A 2-entry skid buffer and an
//   in-flight flag guarantee that backpressure never drops or duplicates a word.
//
// Ports
//   clk        rising-edge clock, shared with the FIFO
//   rst_n      asynchronous active-low reset
//   en         level enable; high starts streaming, low stops reads and drains
//   fifo_empty FIFO empty flag
//   fifo_dout  FIFO registered read data, valid the cycle after fifo_ren
//   fifo_ren   FIFO read strobe (combinational)
//   m_data     stream data (skid buffer head)
//   m_valid    stream word valid
//   m_last     final word of a packet
//   m_ready    downstream accept
//   busy       high whenever the streamer is not idle
//   pkt_cnt    completed packets, wraps modulo 2**CW

module fifo_rd_streamer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PKT_LEN = 16,
    parameter int unsigned CW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_ren,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic [CW-1:0]    pkt_cnt
);

    localparam logic [CW-1:0] LastIdx = CW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic [CW-1:0]    wcnt_q, wcnt_d;
    logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;

    logic             pop;
    logic             drained;
    logic [2:0]       fill;
    logic [2:0]       limit;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf0_q;
    assign m_last  = m_valid & (wcnt_q == LastIdx);
    assign pop     = m_valid & m_ready;
    assign busy    = (state_q != StIdle);
    assign pkt_cnt = pkt_cnt_q;

    // A new read needs a free slot by the time its data lands next cycle; a word
    // leaving this cycle frees one, which is what keeps one word per clock going.
    assign fill     = {1'b0, occ_q} + {2'b00, inflight_q};
    assign limit    = 3'd1 + {2'b00, pop};
    assign fifo_ren = (state_q == StRun) & ~fifo_empty & (fill <= limit);

    // Nothing left to deliver once this cycle's transfer (if any) completes.
    assign drained = ~inflight_q & ((occ_q == 2'd0) | ((occ_q == 2'd1) & pop));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drained) begin
                    state_d = en ? StRun : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Skid buffer: head (buf0) drives the stream, capture goes to the tail.
    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case ({pop, inflight_q})
            2'b01: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_dout;
                end else begin
                    buf1_d = fifo_dout;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b10: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_dout;
                end else begin
                    buf0_d = fifo_dout;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        wcnt_d    = wcnt_q;
        pkt_cnt_d = pkt_cnt_q;
        if (pop) begin
            if (m_last) begin
                wcnt_d    = '0;
                pkt_cnt_d = pkt_cnt_q + CW'(1);
            end else begin
                wcnt_d = wcnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            wcnt_q     <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_ren;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            wcnt_q     <= wcnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
module tb_fifo_rd_streamer;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- DUT A: PKT_LEN=4, CW=8 ----------------
    logic       en_a = 1'b0;
    logic       ready_a = 1'b0;
    logic       ren_a, valid_a, last_a, busy_a;
    logic [7:0] data_a, dout_a, pkt_a;
    logic       empty_a;
    logic [7:0] mem_a [0:255];
    int         wp_a = 0;
    int         rp_a = 0;
    int         idx_a = 0;
    exp_t       exp_a [$];

    assign empty_a = (wp_a == rp_a);

    always @(posedge clk) begin
        if (ren_a && !empty_a) begin
            dout_a <= mem_a[rp_a[7:0]];
            rp_a   <= rp_a + 1;
        end
    end

    fifo_rd_streamer #(.WIDTH(8), .PKT_LEN(4), .CW(8)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_a),
        .fifo_empty (empty_a),
        .fifo_dout  (dout_a),
        .fifo_ren   (ren_a),
        .m_data     (data_a),
        .m_valid    (valid_a),
        .m_last     (last_a),
        .m_ready    (ready_a),
        .busy       (busy_a),
        .pkt_cnt    (pkt_a)
    );

    task automatic push_a(input logic [7:0] d, input bit expect_out);
        mem_a[wp_a[7:0]] = d;
        wp_a = wp_a + 1;
        if (expect_out) begin
            exp_a.push_back('{d: d, l: (idx_a % 4 == 3)});
            idx_a++;
        end
    endtask

    // Monitor A: scoreboard, hold-while-stalled, read-issue legality, timing marks.
    int         reads_a = 0;
    int         xfers_a = 0;
    int         first_ren_cyc = -1;
    int         first_val_cyc = -1;
    int         first_xfer_cyc = -1;
    int         eighth_xfer_cyc = -1;
    bit         stall_a = 0;
    logic [7:0] hold_d;
    logic       hold_l;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_a = 0;
        end else begin
            if (stall_a) begin
                check("stall_valid", 32'(valid_a), 32'd1);
                check("stall_data", 32'(data_a), 32'(hold_d));
                check("stall_last", 32'(last_a), 32'(hold_l));
            end
            if (ren_a) begin
                check("ren_empty", 32'(empty_a), 32'd0);
                check("ren_room", 32'((reads_a - xfers_a - int'(valid_a & ready_a)) <= 1), 32'd1);
                if (first_ren_cyc < 0) first_ren_cyc = cyc;
                reads_a++;
            end
            if (valid_a && first_val_cyc < 0) first_val_cyc = cyc;
            if (valid_a && ready_a) begin
                check("xfer_expected", 32'(exp_a.size() != 0), 32'd1);
                if (exp_a.size() != 0) begin
                    exp_t e;
                    e = exp_a.pop_front();
                    check("data", 32'(data_a), 32'(e.d));
                    check("last", 32'(last_a), 32'(e.l));
                end
                xfers_a++;
                if (xfers_a == 1) first_xfer_cyc = cyc;
                if (xfers_a == 8) eighth_xfer_cyc = cyc;
            end
            stall_a = valid_a && !ready_a;
            hold_d  = data_a;
            hold_l  = last_a;
        end
    end

    // ---------------- DUT B: PKT_LEN=1, CW=2 ----------------
    logic       en_b = 1'b0;
    logic       ready_b = 1'b0;
    logic       ren_b, valid_b, last_b, busy_b;
    logic [7:0] data_b, dout_b;
    logic [1:0] pkt_b;
    logic       empty_b;
    logic [7:0] mem_b [0:255];
    int         wp_b = 0;
    int         rp_b = 0;
    int         pkt_model_b = 0;
    exp_t       exp_b [$];
    int         pkt_exp_b [$];

    assign empty_b = (wp_b == rp_b);

    always @(posedge clk) begin
        if (ren_b && !empty_b) begin
            dout_b <= mem_b[rp_b[7:0]];
            rp_b   <= rp_b + 1;
        end
    end

    fifo_rd_streamer #(.WIDTH(8), .PKT_LEN(1), .CW(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_b),
        .fifo_empty (empty_b),
        .fifo_dout  (dout_b),
        .fifo_ren   (ren_b),
        .m_data     (data_b),
        .m_valid    (valid_b),
        .m_last     (last_b),
        .m_ready    (ready_b),
        .busy       (busy_b),
        .pkt_cnt    (pkt_b)
    );

    task automatic push_b(input logic [7:0] d);
        mem_b[wp_b[7:0]] = d;
        wp_b = wp_b + 1;
        exp_b.push_back('{d: d, l: 1'b1});
        pkt_model_b = (pkt_model_b + 1) % 4;
        pkt_exp_b.push_back(pkt_model_b);
    endtask

    bit pend_b = 0;
    int pend_val_b = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend_b = 0;
        end else begin
            if (pend_b) begin
                check("pkt_cnt_b", 32'(pkt_b), 32'(pend_val_b));
                pend_b = 0;
            end
            if (ren_b) check("ren_empty_b", 32'(empty_b), 32'd0);
            if (valid_b && ready_b) begin
                check("xfer_expected_b", 32'(exp_b.size() != 0), 32'd1);
                if (exp_b.size() != 0) begin
                    exp_t e;
                    e = exp_b.pop_front();
                    check("data_b", 32'(data_b), 32'(e.d));
                    check("last_b", 32'(last_b), 32'(e.l));
                    pend_val_b = pkt_exp_b.pop_front();
                    pend_b = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty_a(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_a.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(exp_a.size()), 32'd0);
    endtask

    initial begin
        // Reset held with words already in the FIFO and en low.
        for (int i = 1; i <= 3; i++) push_a(8'(i), 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 2) rst_n = 1'b1;
            check("rst_ren", 32'(ren_a), 32'd0);
            check("rst_valid", 32'(valid_a), 32'd0);
            check("rst_pkt", 32'(pkt_a), 32'd0);
            check("rst_busy", 32'(busy_a), 32'd0);
        end
        check("rst_last", 32'(last_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);

        // Full-rate streaming of 8 words, two packets.
        for (int i = 4; i <= 8; i++) push_a(8'(i), 1'b1);
        ready_a = 1'b1;
        en_a = 1'b1;
        wait_empty_a(40, "stream_done");
        check("latency", 32'(first_val_cyc - first_ren_cyc), 32'd2);
        check("back_to_back", 32'(eighth_xfer_cyc - first_xfer_cyc), 32'd7);
        step();
        check("pkt_after_stream", 32'(pkt_a), 32'd2);

        // Backpressure pattern 1,0,0,1 over 8 words.
        for (int i = 0; i < 8; i++) push_a(8'(8'h11 + i), 1'b1);
        begin
            int n;
            n = 0;
            while (exp_a.size() != 0 && n < 100) begin
                ready_a = (n % 4 == 0) || (n % 4 == 3);
                step();
                n++;
            end
            check("bp_done", 32'(exp_a.size()), 32'd0);
        end
        ready_a = 1'b1;
        step();
        check("pkt_after_bp", 32'(pkt_a), 32'd4);

        // FIFO runs dry mid-packet.
        push_a(8'h21, 1'b1);
        push_a(8'h22, 1'b1);
        repeat (5) step();
        check("dry_valid", 32'(valid_a), 32'd0);
        check("dry_busy", 32'(busy_a), 32'd1);
        check("dry_pkt", 32'(pkt_a), 32'd4);
        push_a(8'h23, 1'b1);
        push_a(8'h24, 1'b1);
        wait_empty_a(20, "dry_done");
        step();
        check("pkt_after_dry", 32'(pkt_a), 32'd5);

        // en drops in the cycle a read is issued; only that word is delivered.
        ready_a = 1'b0;
        push_a(8'h31, 1'b1);
        push_a(8'h32, 1'b0);
        push_a(8'h33, 1'b0);
        push_a(8'h34, 1'b0);
        begin
            int n;
            n = 0;
            while (n < 10) begin
                @(negedge clk);
                if (ren_a) break;
                n++;
            end
            check("drain_ren_seen", 32'(n < 10), 32'd1);
        end
        en_a = 1'b0;
        repeat (3) step();
        check("drain_stalled", 32'(valid_a), 32'd1);
        ready_a = 1'b1;
        wait_empty_a(20, "drain_done");
        check("drain_busy", 32'(busy_a), 32'd0);
        check("drain_valid", 32'(valid_a), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("drain_no_read", 32'(ren_a), 32'd0);
        end
        check("drain_fifo_left", 32'(wp_a - rp_a), 32'd3);

        // pkt_cnt wrap with CW=2, PKT_LEN=1.
        for (int i = 0; i < 5; i++) push_b(8'(8'h41 + i));
        ready_b = 1'b1;
        en_b = 1'b1;
        begin
            int n;
            n = 0;
            while ((exp_b.size() != 0 || pend_b) && n < 40) begin
                step();
                n++;
            end
            check("wrap_done", 32'(exp_b.size()), 32'd0);
        end
        step();
        check("wrap_final", 32'(pkt_b), 32'd1);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 4; i++) push_b(8'(8'h51 + i));
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ren_b", 32'(ren_b), 32'd0);
        check("arst_valid_b", 32'(valid_b), 32'd0);
        check("arst_last_b", 32'(last_b), 32'd0);
        check("arst_data_b", 32'(data_b), 32'd0);
        check("arst_busy_b", 32'(busy_b), 32'd0);
        check("arst_pkt_b", 32'(pkt_b), 32'd0);
        check("arst_pkt_a", 32'(pkt_a), 32'd0);
        check("arst_busy_a", 32'(busy_a), 32'd0);
        exp_b.delete();
        pkt_exp_b.delete();
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule
